// File: rtl/sync_fifo_fwft_prog.sv
// Single-clock first-word-fall-through FIFO of arbitrary depth.
// Registered-read RAM feeds a two-entry prefetch stage (output register plus cache).
module sync_fifo_fwft_prog #(
  parameter  int C_WIDTH         = 32,
  parameter  int C_DEPTH         = 1024,
  parameter  int C_AFULL_THRESH  = 1020,
  parameter  int C_AEMPTY_THRESH = 4,
  localparam int C_CNT_BITS      = $clog2(C_DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [C_WIDTH-1:0]    i_wr_data,
  input  logic                  i_wr_en,
  output logic                  o_wr_full,
  output logic [C_WIDTH-1:0]    o_rd_data,
  input  logic                  i_rd_en,
  output logic                  o_rd_empty,
  output logic [C_CNT_BITS-1:0] o_count,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic                  o_overflow,
  output logic                  o_underflow,
  input  logic                  i_flag_clr
);

  localparam int C_PTR_BITS = $clog2(C_DEPTH);

  logic [C_WIDTH-1:0]    r_mem [C_DEPTH];
  logic [C_WIDTH-1:0]    r_ram_q;
  logic [C_PTR_BITS-1:0] r_wr_ptr;
  logic [C_PTR_BITS-1:0] r_rd_ptr;
  logic [C_CNT_BITS-1:0] r_ram_cnt;
  logic [C_CNT_BITS-1:0] r_count;
  logic                  r_rd_pending;
  logic                  r_out_valid;
  logic [C_WIDTH-1:0]    r_out_data;
  logic                  r_cache_valid;
  logic [C_WIDTH-1:0]    r_cache_data;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_rd_issue;
  logic [1:0]            w_occ;
  logic [C_CNT_BITS-1:0] w_count_nxt;
  logic [C_CNT_BITS-1:0] w_ram_cnt_nxt;
  logic                  w_out_valid_nxt;
  logic [C_WIDTH-1:0]    w_out_data_nxt;
  logic                  w_cache_valid_nxt;
  logic [C_WIDTH-1:0]    w_cache_data_nxt;

  function automatic logic [C_PTR_BITS-1:0] ptr_inc(input logic [C_PTR_BITS-1:0] p);
    return (p == C_PTR_BITS'(C_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_wr_acc = i_wr_en & ~r_full;
  assign w_rd_acc = i_rd_en & r_out_valid;

  // Words in flight from the RAM count as occupied prefetch slots, so the stage never holds more than two.
  assign w_occ      = {1'b0, r_out_valid} + {1'b0, r_cache_valid} + {1'b0, r_rd_pending};
  assign w_rd_issue = (r_ram_cnt != '0) && ((w_occ - {1'b0, w_rd_acc}) < 2'd2);

  assign w_count_nxt   = r_count + C_CNT_BITS'(w_wr_acc) - C_CNT_BITS'(w_rd_acc);
  assign w_ram_cnt_nxt = r_ram_cnt + C_CNT_BITS'(w_wr_acc) - C_CNT_BITS'(w_rd_issue);

  always_comb begin
    w_out_valid_nxt   = r_out_valid & ~w_rd_acc;
    w_out_data_nxt    = r_out_data;
    w_cache_valid_nxt = r_cache_valid;
    w_cache_data_nxt  = r_cache_data;
    if (w_rd_acc && r_cache_valid) begin
      w_out_valid_nxt   = 1'b1;
      w_out_data_nxt    = r_cache_data;
      w_cache_valid_nxt = 1'b0;
    end
    if (r_rd_pending) begin
      if (!w_out_valid_nxt) begin
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = r_ram_q;
      end else begin
        w_cache_valid_nxt = 1'b1;
        w_cache_data_nxt  = r_ram_q;
      end
    end
  end

  // RAM has no reset so it can map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= i_wr_data;
    if (w_rd_issue) r_ram_q <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_ram_cnt     <= '0;
      r_count       <= '0;
      r_rd_pending  <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_cache_valid <= 1'b0;
      r_cache_data  <= '0;
      r_full        <= 1'b0;
      r_afull       <= 1'b0;
      r_aempty      <= 1'b1;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd_issue) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_ram_cnt     <= w_ram_cnt_nxt;
      r_count       <= w_count_nxt;
      r_rd_pending  <= w_rd_issue;
      r_out_valid   <= w_out_valid_nxt;
      r_out_data    <= w_out_data_nxt;
      r_cache_valid <= w_cache_valid_nxt;
      r_cache_data  <= w_cache_data_nxt;
      r_full        <= (w_count_nxt == C_CNT_BITS'(C_DEPTH));
      r_afull       <= (w_count_nxt >= C_CNT_BITS'(C_AFULL_THRESH));
      r_aempty      <= (w_count_nxt <= C_CNT_BITS'(C_AEMPTY_THRESH));
      if (i_flag_clr) r_overflow <= 1'b0;
      else if (i_wr_en && r_full) r_overflow <= 1'b1;
      if (i_flag_clr) r_underflow <= 1'b0;
      else if (i_rd_en && !r_out_valid) r_underflow <= 1'b1;
    end
  end

  assign o_wr_full      = r_full;
  assign o_rd_data      = r_out_data;
  assign o_rd_empty     = ~r_out_valid;
  assign o_count        = r_count;
  assign o_almost_full  = r_afull;
  assign o_almost_empty = r_aempty;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_fwft_prog.sv
// Testbench for sync_fifo_fwft_prog: directed vector table for the corner cases,
// then a random burst with a mid-burst asynchronous reset checked against a data queue.
module tb_sync_fifo_fwft_prog;

  localparam int DEPTH = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wrData = '0;
  logic       wrEn = 1'b0;
  logic       wrFull;
  logic [7:0] rdData;
  logic       rdEn = 1'b0;
  logic       rdEmpty;
  logic [2:0] count;
  logic       almostFull;
  logic       almostEmpty;
  logic       overflow;
  logic       underflow;
  logic       flagClr = 1'b0;

  int nCompared = 0;
  int nMismatched = 0;

  typedef struct {
    logic       wrEn;
    logic [7:0] wrData;
    logic       rdEn;
    logic       flagClr;
    int         expCount;
    logic       expEmpty;
    logic       expFull;
    logic       expAfull;
    logic       expAempty;
    logic       expOvf;
    logic       expUdf;
    logic       chkData;
    logic [7:0] expData;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];

  sync_fifo_fwft_prog #(
    .C_WIDTH(8), .C_DEPTH(DEPTH), .C_AFULL_THRESH(5), .C_AEMPTY_THRESH(1)
  ) dut (
    .i_clk(clock), .i_rst(reset),
    .i_wr_data(wrData), .i_wr_en(wrEn), .o_wr_full(wrFull),
    .o_rd_data(rdData), .i_rd_en(rdEn), .o_rd_empty(rdEmpty),
    .o_count(count), .o_almost_full(almostFull), .o_almost_empty(almostEmpty),
    .o_overflow(overflow), .o_underflow(underflow), .i_flag_clr(flagClr)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic re, input logic cl,
                              input int cnt, input logic em, input logic fu, input logic af,
                              input logic ae, input logic ov, input logic ud,
                              input logic chk, input logic [7:0] d);
    vec_t v;
    v.wrEn = we; v.wrData = wd; v.rdEn = re; v.flagClr = cl;
    v.expCount = cnt; v.expEmpty = em; v.expFull = fu; v.expAfull = af;
    v.expAempty = ae; v.expOvf = ov; v.expUdf = ud; v.chkData = chk; v.expData = d;
    return v;
  endfunction

  task automatic compareValue(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wrEn = v.wrEn; wrData = v.wrData; rdEn = v.rdEn; flagClr = v.flagClr;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    compareValue("count", idx, 32'(count), 32'(v.expCount));
    compareValue("rdEmpty", idx, 32'(rdEmpty), 32'(v.expEmpty));
    compareValue("wrFull", idx, 32'(wrFull), 32'(v.expFull));
    compareValue("almostFull", idx, 32'(almostFull), 32'(v.expAfull));
    compareValue("almostEmpty", idx, 32'(almostEmpty), 32'(v.expAempty));
    compareValue("overflow", idx, 32'(overflow), 32'(v.expOvf));
    compareValue("underflow", idx, 32'(underflow), 32'(v.expUdf));
    if (v.chkData) compareValue("rdData", idx, 32'(rdData), 32'(v.expData));
  endtask

  task automatic checkReset(input int idx);
    compareValue("rstCount", idx, 32'(count), 32'd0);
    compareValue("rstEmpty", idx, 32'(rdEmpty), 32'd1);
    compareValue("rstFull", idx, 32'(wrFull), 32'd0);
    compareValue("rstAfull", idx, 32'(almostFull), 32'd0);
    compareValue("rstAempty", idx, 32'(almostEmpty), 32'd1);
    compareValue("rstOvf", idx, 32'(overflow), 32'd0);
    compareValue("rstUdf", idx, 32'(underflow), 32'd0);
    compareValue("rstData", idx, 32'(rdData), 32'd0);
  endtask

  initial begin
    int mCount;
    logic wrAcc;
    logic [7:0] expWord;

    // Single word latency, then fill to full and overflow.
    vecs.push_back(mk(1, 8'hA5, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 8'hA5));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 8'hA5));
    vecs.push_back(mk(1, 8'h01, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 8'hA5));
    vecs.push_back(mk(1, 8'h02, 0, 0, 2, 1, 0, 0, 0, 0, 0, 1, 8'hA5));
    vecs.push_back(mk(1, 8'h03, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h04, 0, 0, 4, 0, 0, 0, 0, 0, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h05, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h06, 0, 0, 6, 0, 1, 1, 0, 0, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h07, 0, 0, 6, 0, 1, 1, 0, 1, 0, 1, 8'h01));
    // Drain from full across the pointer wrap.
    vecs.push_back(mk(0, 8'h00, 0, 1, 6, 0, 1, 1, 0, 0, 0, 1, 8'h01));
    vecs.push_back(mk(0, 8'h00, 1, 0, 5, 0, 0, 1, 0, 0, 0, 1, 8'h02));
    vecs.push_back(mk(0, 8'h00, 1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 8'h03));
    vecs.push_back(mk(0, 8'h00, 1, 0, 3, 0, 0, 0, 0, 0, 0, 1, 8'h04));
    vecs.push_back(mk(0, 8'h00, 1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 8'h05));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 8'h06));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 8'h06));
    // Refill, then simultaneous write and read while full.
    vecs.push_back(mk(1, 8'h11, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 8'h06));
    vecs.push_back(mk(1, 8'h12, 0, 0, 2, 1, 0, 0, 0, 0, 0, 1, 8'h06));
    vecs.push_back(mk(1, 8'h13, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 8'h11));
    vecs.push_back(mk(1, 8'h14, 0, 0, 4, 0, 0, 0, 0, 0, 0, 1, 8'h11));
    vecs.push_back(mk(1, 8'h15, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1, 8'h11));
    vecs.push_back(mk(1, 8'h16, 0, 0, 6, 0, 1, 1, 0, 0, 0, 1, 8'h11));
    vecs.push_back(mk(1, 8'h17, 1, 0, 5, 0, 0, 1, 0, 1, 0, 1, 8'h12));
    vecs.push_back(mk(0, 8'h00, 1, 0, 4, 0, 0, 0, 0, 1, 0, 1, 8'h13));
    vecs.push_back(mk(0, 8'h00, 1, 0, 3, 0, 0, 0, 0, 1, 0, 1, 8'h14));
    vecs.push_back(mk(0, 8'h00, 1, 0, 2, 0, 0, 0, 0, 1, 0, 1, 8'h15));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 8'h16));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 1, 0, 1, 8'h16));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 8'h16));
    // Write and read into an empty FIFO, then flag clear priority.
    vecs.push_back(mk(1, 8'h3C, 1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 8'h16));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 8'h16));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 8'h3C));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 8'h3C));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 8'h3C));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 0, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 8'h3C));

    repeat (2) @(posedge clock);
    #1;
    checkReset(0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clock);
      #1;
      checkOutput(i, vecs[i]);
    end
    flagClr = 1'b0;

    // Random traffic; reads are only issued while a word is presented.
    mCount = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 20) begin
        wrEn = 1'b0;
        rdEn = 1'b0;
        #3 reset = 1'b1;
        #1 checkReset(c);
        #2 reset = 1'b0;
        sb.delete();
        mCount = 0;
        @(posedge clock);
        #1;
        continue;
      end
      wrEn   = ($urandom_range(0, 2) != 0);
      wrData = 8'($urandom);
      rdEn   = ($urandom_range(0, 1) == 1) && !rdEmpty;
      wrAcc  = wrEn && (mCount < DEPTH);
      if (rdEn) begin
        if (sb.size() == 0) begin
          compareValue("sbUnderrun", c, 32'(rdData), 32'hFFFF_FFFF);
        end else begin
          expWord = sb.pop_front();
          compareValue("sbData", c, 32'(rdData), 32'(expWord));
        end
      end
      if (wrAcc) sb.push_back(wrData);
      mCount = mCount + int'(wrAcc) - int'(rdEn);
      @(posedge clock);
      #1;
      compareValue("sbCount", c, 32'(count), 32'(mCount));
      compareValue("sbFull", c, 32'(wrFull), 32'(mCount == DEPTH));
    end

    wrEn = 1'b0;
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      rdEn = !rdEmpty;
      if (rdEn) begin
        expWord = sb.pop_front();
        compareValue("drainData", k, 32'(rdData), 32'(expWord));
        mCount = mCount - 1;
      end
      @(posedge clock);
      #1;
    end
    rdEn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    compareValue("drainLeft", 0, 32'(sb.size()), 32'd0);
    compareValue("drainCount", 0, 32'(count), 32'(mCount));
    compareValue("drainEmpty", 0, 32'(rdEmpty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
